// File: rtl/key_event_sched_if.sv
// Stream bundle between key_event_sched and its IR source / event consumer.
// Handshake rule for both streams: a transfer happens on a rising clk edge
// where valid and ready are both 1; a producer holding valid keeps its
// payload stable until that edge, and ready may depend on the receiver's state.
interface key_event_sched_if #(
  parameter int CODE_W = 8
);
  logic              ir_valid;
  logic [CODE_W-1:0] ir_code;
  logic              ir_ready;
  logic              evt_valid;
  logic              evt_ready;
  logic              evt_src;
  logic [1:0]        evt_type;
  logic [CODE_W-1:0] evt_code;

  // Block side: accepts IR commands, produces events.
  modport slave (
    input  ir_valid, ir_code, evt_ready,
    output ir_ready, evt_valid, evt_src, evt_type, evt_code
  );

  // Environment side: offers IR commands, consumes events.
  modport master (
    output ir_valid, ir_code, evt_ready,
    input  ir_ready, evt_valid, evt_src, evt_type, evt_code
  );
endinterface

// File: rtl/key_event_sched.sv
// Turns debounced key levels into PRESS/LONG/REPEAT/RELEASE events, merges
// them round-robin with IR commands and presents one registered event.
// Pipeline: key FSM decision -> 1-entry key slot -> output register;
//           IR handshake    -> 1-entry IR slot  -> output register.
module key_event_sched #(
  parameter int          KEY_NUM    = 4,
  parameter logic [23:0] LONG_CNT   = 24'd12000000,
  parameter logic [23:0] REPEAT_CNT = 24'd2400000,
  parameter int          CODE_W     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [KEY_NUM-1:0] key_level_n,
  key_event_sched_if.slave   bus,
  output logic               key_busy,
  output logic               evt_drop,
  output logic [1:0]         key_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, REP = 2'd2} state_t;

  localparam logic [1:0] T_PRESS   = 2'b00;
  localparam logic [1:0] T_LONG    = 2'b01;
  localparam logic [1:0] T_REPEAT  = 2'b10;
  localparam logic [1:0] T_RELEASE = 2'b11;

  state_t       state_q, state_d;
  logic [23:0]  timer_q, timer_d;
  logic [2:0]   idx_q, idx_d;
  logic [KEY_NUM-1:0] prev_q;
  logic [7:0]   level_pad, edge_pad;
  logic [2:0]   first_idx;
  logic         emit;
  logic [1:0]   emit_type;
  logic [2:0]   emit_idx;

  logic         key_full, ir_full;
  logic [1:0]   key_type;
  logic [2:0]   key_idx;
  logic [CODE_W-1:0] ir_code_q;
  logic         last_ir;
  logic         grant_key, load, key_drain, ir_drain, ir_ready;

  logic              evt_valid_q, evt_src_q;
  logic [1:0]        evt_type_q;
  logic [CODE_W-1:0] evt_code_q;

  // Pad key vectors to 8 bits so a 3-bit index is always in range;
  // absent keys read as released and never produce edges.
  always_comb begin
    level_pad = '1;
    level_pad[KEY_NUM-1:0] = key_level_n;
    edge_pad = '0;
    edge_pad[KEY_NUM-1:0] = ~key_level_n & prev_q;
    first_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (edge_pad[i]) first_idx = i[2:0];
    end
  end

  // Previous levels for edge detection; reset to released so a key held
  // through reset release produces a PRESS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= '1;
    else        prev_q <= key_level_n;
  end

  // Key FSM state, hold timer and active key index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= 24'd0;
      idx_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
    end
  end

  // Key FSM next state and event decision; release beats timer expiry.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    idx_d     = idx_q;
    emit      = 1'b0;
    emit_type = T_PRESS;
    emit_idx  = idx_q;
    case (state_q)
      IDLE: begin
        if (|edge_pad) begin
          emit     = 1'b1;
          idx_d    = first_idx;
          emit_idx = first_idx;
          timer_d  = 24'd0;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (level_pad[idx_q]) begin
          emit      = 1'b1;
          emit_type = T_RELEASE;
          state_d   = IDLE;
        end else if (timer_q == LONG_CNT - 24'd1) begin
          emit      = 1'b1;
          emit_type = T_LONG;
          timer_d   = 24'd0;
          state_d   = REP;
        end else begin
          timer_d = timer_q + 24'd1;
        end
      end
      REP: begin
        if (level_pad[idx_q]) begin
          emit      = 1'b1;
          emit_type = T_RELEASE;
          state_d   = IDLE;
        end else if (timer_q == REPEAT_CNT - 24'd1) begin
          emit      = 1'b1;
          emit_type = T_REPEAT;
          timer_d   = 24'd0;
        end else begin
          timer_d = timer_q + 24'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Arbitration: key wins unless the IR slot is full and key was granted last.
  always_comb begin
    grant_key = key_full & (~ir_full | last_ir);
    load      = (~evt_valid_q | bus.evt_ready) & (key_full | ir_full);
    key_drain = load & grant_key;
    ir_drain  = load & ~grant_key;
    ir_ready  = ~ir_full | ir_drain;
  end

  // Key slot: new event lands if the slot is free or being drained,
  // otherwise it is discarded and evt_drop pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_full <= 1'b0;
      key_type <= 2'b00;
      key_idx  <= 3'd0;
      evt_drop <= 1'b0;
    end else begin
      evt_drop <= emit & key_full & ~key_drain;
      if (emit && (!key_full || key_drain)) begin
        key_full <= 1'b1;
        key_type <= emit_type;
        key_idx  <= emit_idx;
      end else if (key_drain) begin
        key_full <= 1'b0;
      end
    end
  end

  // IR slot: capture on handshake, empty when the output register takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_full   <= 1'b0;
      ir_code_q <= '0;
    end else if (bus.ir_valid && ir_ready) begin
      ir_full   <= 1'b1;
      ir_code_q <= bus.ir_code;
    end else if (ir_drain) begin
      ir_full <= 1'b0;
    end
  end

  // Output register; fields only change on a load, so they hold during stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid_q <= 1'b0;
      evt_src_q   <= 1'b0;
      evt_type_q  <= 2'b00;
      evt_code_q  <= '0;
      last_ir     <= 1'b1;
    end else if (load) begin
      evt_valid_q <= 1'b1;
      evt_src_q   <= ~grant_key;
      evt_type_q  <= grant_key ? key_type : T_PRESS;
      evt_code_q  <= grant_key ? CODE_W'(key_idx) : ir_code_q;
      last_ir     <= ~grant_key;
    end else if (bus.evt_ready) begin
      evt_valid_q <= 1'b0;
    end
  end

  assign bus.ir_ready  = ir_ready;
  assign bus.evt_valid = evt_valid_q;
  assign bus.evt_src   = evt_src_q;
  assign bus.evt_type  = evt_type_q;
  assign bus.evt_code  = evt_code_q;
  assign key_busy      = (state_q != IDLE);
  assign key_state     = state_q;

endmodule

// File: tb/tb_key_event_sched.sv
// Directed bench for key_event_sched with an expected-event queue and a
// monitor that checks each accepted output event against it.
module tb_key_event_sched;
  localparam int CODE_W = 8;
  localparam int EW     = 1 + 2 + CODE_W;
  localparam logic [1:0] PR = 2'b00, LG = 2'b01, RP = 2'b10, RL = 2'b11;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] key_level_n;
  logic       key_busy, evt_drop;
  logic [1:0] key_state;

  key_event_sched_if #(.CODE_W(CODE_W)) bus();

  key_event_sched #(
    .KEY_NUM(4), .LONG_CNT(24'd10), .REPEAT_CNT(24'd4), .CODE_W(CODE_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_level_n(key_level_n), .bus(bus),
    .key_busy(key_busy), .evt_drop(evt_drop), .key_state(key_state)
  );

  // Scoreboard state
  logic [EW-1:0] exp_q[$];
  int pop_cyc[$];
  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int drop_cnt = 0;

  function automatic logic [EW-1:0] mk(input logic src, input logic [1:0] t,
                                       input logic [CODE_W-1:0] c);
    return {src, t, c};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_evt_valid"}, 32'(bus.evt_valid), 0);
    check({tag, "_evt_src"},   32'(bus.evt_src), 0);
    check({tag, "_evt_type"},  32'(bus.evt_type), 0);
    check({tag, "_evt_code"},  32'(bus.evt_code), 0);
    check({tag, "_ir_ready"},  32'(bus.ir_ready), 1);
    check({tag, "_key_busy"},  32'(key_busy), 0);
    check({tag, "_evt_drop"},  32'(evt_drop), 0);
  endtask

  // Hold key 0 for n cycles and check event order plus spacing.
  task automatic hold_key0(input int n, input int last_gap);
    int gaps[5];
    gaps = '{10, 4, 4, 4, last_gap};
    pop_cyc.delete();
    key_level_n[0] = 1'b0;
    exp_q.push_back(mk(0, PR, 0));
    exp_q.push_back(mk(0, LG, 0));
    exp_q.push_back(mk(0, RP, 0));
    exp_q.push_back(mk(0, RP, 0));
    exp_q.push_back(mk(0, RP, 0));
    exp_q.push_back(mk(0, RL, 0));
    tick(n);
    key_level_n[0] = 1'b1;
    tick(6);
    check("hold_queue_empty", 32'(exp_q.size()), 0);
    check("hold_event_count", 32'(pop_cyc.size()), 6);
    if (pop_cyc.size() == 6) begin
      for (int i = 0; i < 5; i++)
        check("hold_gap", 32'(pop_cyc[i+1] - pop_cyc[i]), 32'(gaps[i]));
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every accepted event must match the head of the expected queue.
  always @(negedge clk) begin
    if (evt_drop) drop_cnt++;
    if (rst_n && bus.evt_valid && bus.evt_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL evt_unexpected: got %0h expected none",
                 {bus.evt_src, bus.evt_type, bus.evt_code});
      end else begin
        check("evt", 32'({bus.evt_src, bus.evt_type, bus.evt_code}), 32'(exp_q.pop_front()));
        pop_cyc.push_back(cyc);
      end
    end
  end

  // Stimulus
  initial begin
    key_level_n   = 4'hF;
    bus.ir_valid  = 1'b0;
    bus.ir_code   = '0;
    bus.evt_ready = 1'b1;
    #12;
    check_reset_outputs("rst");
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // IR latency: handshake at N, valid at N+2
    bus.ir_code  = 8'h3C;
    bus.ir_valid = 1'b1;
    exp_q.push_back(mk(1, PR, 8'h3C));
    tick(1);
    bus.ir_valid = 1'b0;
    check("ir_lat_n1", 32'(bus.evt_valid), 0);
    tick(1);
    check("ir_lat_n2", 32'(bus.evt_valid), 1);
    tick(3);

    // Short press of key 2: PRESS then RELEASE, no LONG
    key_level_n = 4'b1011;
    exp_q.push_back(mk(0, PR, 2));
    tick(1);
    check("k2_lat_n1", 32'(bus.evt_valid), 0);
    check("k2_busy", 32'(key_busy), 1);
    tick(1);
    check("k2_lat_n2", 32'(bus.evt_valid), 1);
    check("k2_code", 32'(bus.evt_code), 2);
    tick(3);
    key_level_n = 4'hF;
    exp_q.push_back(mk(0, RL, 2));
    tick(4);
    check("k2_idle", 32'(key_busy), 0);
    check("k2_queue_empty", 32'(exp_q.size()), 0);

    // Long holds: release before and exactly at REPEAT expiry
    hold_key0(25, 3);
    hold_key0(26, 4);

    // Keys 1 and 3 together: only key 1 reported
    key_level_n = 4'b0101;
    exp_q.push_back(mk(0, PR, 1));
    tick(4);
    key_level_n = 4'b0111;
    exp_q.push_back(mk(0, RL, 1));
    tick(6);
    check("k13_idle", 32'(key_busy), 0);
    key_level_n = 4'hF;
    tick(4);
    check("k13_queue_empty", 32'(exp_q.size()), 0);

    // Stall with key PRESS in output and IR waiting; then round-robin
    bus.evt_ready = 1'b0;
    key_level_n[0] = 1'b0;
    exp_q.push_back(mk(0, PR, 0));
    tick(1);
    bus.ir_code  = 8'h45;
    bus.ir_valid = 1'b1;
    exp_q.push_back(mk(1, PR, 8'h45));
    tick(1);
    bus.ir_valid = 1'b0;
    check("stall_ir_ready", 32'(bus.ir_ready), 0);
    tick(2);
    check("stall_a_valid", 32'(bus.evt_valid), 1);
    check("stall_a_fields", 32'({bus.evt_src, bus.evt_type, bus.evt_code}), 32'(mk(0, PR, 0)));
    key_level_n[0] = 1'b1;
    exp_q.push_back(mk(0, RL, 0));
    tick(3);
    check("stall_b_fields", 32'({bus.evt_src, bus.evt_type, bus.evt_code}), 32'(mk(0, PR, 0)));
    check("stall_b_ir_ready", 32'(bus.ir_ready), 0);
    bus.evt_ready = 1'b1;
    tick(5);
    check("stall_queue_empty", 32'(exp_q.size()), 0);
    check("stall_ir_ready_back", 32'(bus.ir_ready), 1);

    // Key slot full while stalled: one drop, original events survive
    bus.evt_ready = 1'b0;
    drop_cnt = 0;
    key_level_n = 4'b1011;
    exp_q.push_back(mk(0, PR, 2));
    tick(3);
    key_level_n = 4'hF;
    exp_q.push_back(mk(0, RL, 2));
    tick(3);
    key_level_n = 4'b1101;
    tick(3);
    check("drop_once", 32'(drop_cnt), 1);
    check("drop_survive", 32'({bus.evt_src, bus.evt_type, bus.evt_code}), 32'(mk(0, PR, 2)));
    bus.evt_ready = 1'b1;
    tick(2);
    key_level_n = 4'hF;
    exp_q.push_back(mk(0, RL, 1));
    tick(5);
    check("drop_queue_empty", 32'(exp_q.size()), 0);
    check("drop_final", 32'(drop_cnt), 1);

    // Reset while stalled in REP; held key gives a fresh PRESS afterwards
    bus.evt_ready = 1'b0;
    key_level_n[0] = 1'b0;
    exp_q.push_back(mk(0, PR, 0));
    tick(14);
    check("rep_state", 32'(key_state), 2);
    check("rep_valid", 32'(bus.evt_valid), 1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_reset_outputs("midrst");
    tick(2);
    bus.evt_ready = 1'b1;
    rst_n = 1'b1;
    exp_q.push_back(mk(0, PR, 0));
    tick(1);
    check("fresh_lat_n1", 32'(bus.evt_valid), 0);
    tick(1);
    check("fresh_lat_n2", 32'(bus.evt_valid), 1);
    tick(2);
    key_level_n[0] = 1'b1;
    exp_q.push_back(mk(0, RL, 0));
    tick(5);

    check("final_queue_empty", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
